// File: rtl/rf_bus_pkg.sv
// rf_bus_pkg: shared types and constants for the register-file bus slave.
//   state_e     one-hot FSM state encoding (6 bits)
//   RF_BASE_ADDR / RF_SPAN  default address window (first word, size in words)
//   RF_LEN_W    width of the burst-length field (beats minus one)
//   in_window() true when a word address falls inside [base, base+span-1]
package rf_bus_pkg;

  localparam logic [15:0] RF_BASE_ADDR = 16'h0120;
  localparam int unsigned RF_SPAN      = 16;
  localparam int unsigned RF_LEN_W     = 4;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WRITE   = 6'b000010,
    ST_RD_ADDR = 6'b000100,
    ST_RD_CAP  = 6'b001000,
    ST_DONE    = 6'b010000,
    ST_ERR     = 6'b100000
  } state_e;

  // Compared as 32-bit quantities so that base+span cannot overflow the
  // bus address width at the top of the address map.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base = 32'(RF_BASE_ADDR),
                                     input logic [31:0] span = RF_SPAN);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/rf_bus_addr_gen.sv
// rf_bus_addr_gen: window offset counter plus burst beat down-counter.
//   clk, reset  clock and asynchronous active-high reset
//   load_i      start a burst: offset <= off_i, remaining beats <= len_i
//   off_i       starting offset inside the window
//   len_i       burst length minus one
//   inc_i       a beat completed: advance offset (mod SPAN), count one beat down
//   off_o       current offset inside the window
//   last_o      the current beat is the final one of the burst
module rf_bus_addr_gen
  import rf_bus_pkg::*;
#(
  parameter int unsigned OFF_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [OFF_W-1:0]    off_i,
  input  logic [RF_LEN_W-1:0] len_i,
  input  logic                inc_i,
  output logic [OFF_W-1:0]    off_o,
  output logic                last_o
);

  logic [OFF_W-1:0]    off_q, off_d;
  logic [RF_LEN_W-1:0] cnt_q, cnt_d;

  // The offset is exactly log2(SPAN) bits wide, so the natural roll-over of
  // the adder is the modulo-SPAN wrap back to the window base.
  always_comb begin
    off_d = off_q;
    cnt_d = cnt_q;
    if (load_i) begin
      off_d = off_i;
      cnt_d = len_i;
    end else if (inc_i) begin
      off_d = off_q + OFF_W'(1);
      cnt_d = cnt_q - RF_LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q <= '0;
      cnt_q <= '0;
    end else begin
      off_q <= off_d;
      cnt_q <= cnt_d;
    end
  end

  assign off_o  = off_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rf_bus_slave.sv
// rf_bus_slave: bus slave in front of the register file. Accepts single or
// burst read/write requests, checks them against a fixed word window and
// turns them into register-file write strobes and read address/capture steps.
//   clk, reset        clock, asynchronous active-high reset
//   s_sel, s_ready    request strobe / slave idle (accept on s_sel && s_ready)
//   s_wr, s_addr, s_len  request kind, start word address, beats minus one
//   s_valid, s_wdata  write beat handshake and data
//   s_rvalid, s_rdata read beat pulse and data
//   s_ack, s_err      completion pulse, error flag (out-of-window request)
//   rf_we, rf_waddr, rf_wdata  register-file write port
//   rf_raddr, rf_rdata         register-file read port (data one cycle after address)
module rf_bus_slave
  import rf_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RF_BASE_ADDR),
  parameter int unsigned       SPAN      = RF_SPAN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [RF_LEN_W-1:0] s_len,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_wdata,
  output logic                s_ready,
  output logic                s_rvalid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_ack,
  output logic                s_err,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [ADDR_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]   rf_rdata
);

  localparam int unsigned OFF_W = (SPAN > 1) ? $clog2(SPAN) : 1;

  state_e state_q, state_d;

  logic              s_ready_q, s_ready_d;
  logic              s_rvalid_q, s_rvalid_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
  logic              s_ack_q, s_ack_d;
  logic              s_err_q, s_err_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;

  logic              ag_load, ag_inc, ag_last;
  logic [OFF_W-1:0]  ag_off, start_off;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept, hit;

  assign accept    = s_sel && s_ready_q;
  assign hit       = in_window(32'(s_addr), 32'(BASE_ADDR), 32'(SPAN));
  // Only the low bits matter: an in-window address differs from the base by
  // less than SPAN, and an out-of-window one never touches the register file.
  assign start_off = OFF_W'(s_addr - BASE_ADDR);
  assign cur_addr  = BASE_ADDR + ADDR_W'(ag_off);

  rf_bus_addr_gen #(
    .OFF_W (OFF_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load_i (ag_load),
    .off_i  (start_off),
    .len_i  (s_len),
    .inc_i  (ag_inc),
    .off_o  (ag_off),
    .last_o (ag_last)
  );

  // Next state and next registered outputs. Pulse outputs default low, data
  // and address outputs hold their last value.
  always_comb begin
    state_d    = state_q;
    s_rvalid_d = 1'b0;
    s_rdata_d  = s_rdata_q;
    s_ack_d    = 1'b0;
    s_err_d    = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_raddr_d = rf_raddr_q;
    ag_load    = 1'b0;
    ag_inc     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ag_load = 1'b1;
          if (!hit) begin
            state_d = ST_ERR;
            s_ack_d = 1'b1;
            s_err_d = 1'b1;
          end else if (s_wr) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WRITE: begin
        if (s_valid) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = cur_addr;
          rf_wdata_d = s_wdata;
          ag_inc     = 1'b1;
          if (ag_last) begin
            state_d = ST_DONE;
            s_ack_d = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        rf_raddr_d = cur_addr;
        state_d    = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        s_rdata_d  = rf_rdata;
        s_rvalid_d = 1'b1;
        ag_inc     = 1'b1;
        if (ag_last) begin
          state_d = ST_DONE;
          s_ack_d = 1'b1;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Ready is registered, so it is computed from where the FSM is heading.
    s_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b1;
      s_rvalid_q <= 1'b0;
      s_rdata_q  <= '0;
      s_ack_q    <= 1'b0;
      s_err_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_raddr_q <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      s_rvalid_q <= s_rvalid_d;
      s_rdata_q  <= s_rdata_d;
      s_ack_q    <= s_ack_d;
      s_err_q    <= s_err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_raddr_q <= rf_raddr_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign s_rvalid = s_rvalid_q;
  assign s_rdata  = s_rdata_q;
  assign s_ack    = s_ack_q;
  assign s_err    = s_err_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_raddr = rf_raddr_q;

endmodule

// File: tb/tb_rf_bus_slave.sv
// Bench for rf_bus_slave: the slave is attached to a behavioural register
// file (asynchronous read, write on the clock edge while rf_we is high).
// Each transaction is predicted from the bus rules: window check, wrapped
// word addresses, beat timing relative to the accepting edge, and a shadow
// copy of the register-file contents.
module tb_rf_bus_slave;
  import rf_bus_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam logic [15:0] BASE   = 16'h0120;
  localparam int          SPAN   = 16;
  localparam int M_NONE = 0, M_RAND = 1, M_STALL2 = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_sel, s_wr, s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]        s_len;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ready, s_rvalid, s_ack, s_err, rf_we;
  logic [DATA_W-1:0] s_rdata, rf_wdata, rf_rdata;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr;

  always #5 clk = ~clk;

  rf_bus_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .SPAN(SPAN)
  ) dut (
    .clk(clk), .reset(reset),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_len(s_len),
    .s_valid(s_valid), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_ack(s_ack), .s_err(s_err),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  // Register file model (low 8 address bits select the word).
  logic [63:0] rf_mem  [0:255];
  logic [63:0] pre_mem [0:255];
  logic [63:0] ref_mem [0:255];
  bit          pre_go;

  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= pre_mem[i];
    end else if (rf_we) begin
      rf_mem[rf_waddr[7:0]] <= rf_wdata;
    end
  end
  assign rf_rdata = rf_mem[rf_raddr[7:0]];

  // Edge numbering: edge_n holds the number of the most recent rising edge.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Acceptance observer.
  int acc_n = 0, acc_edge = 0;
  bit busy = 0;
  always @(posedge clk) begin
    if (s_sel && s_ready && !reset) begin
      acc_n++;
      acc_edge = edge_n + 1;
      busy = 1;
    end
  end

  // Output monitor; each event is stamped with the edge that samples it.
  typedef struct { int t; logic [15:0] a; logic [63:0] d; } ev_t;
  ev_t we_q[$];
  ev_t rd_q[$];
  int  ack_t[$];
  bit  err_q[$];
  int  ready_bad = 0, stray_err = 0;

  always @(negedge clk) begin
    if (rf_we)    we_q.push_back('{t: edge_n + 1, a: rf_waddr, d: rf_wdata});
    if (s_rvalid) rd_q.push_back('{t: edge_n + 1, a: rf_raddr, d: s_rdata});
    if (busy && s_ready) ready_bad++;
    if (s_err && !s_ack) stray_err++;
    if (s_ack) begin
      ack_t.push_back(edge_n + 1);
      err_q.push_back(s_err);
      busy = 0;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] win_addr(input int off);
    return 16'(int'(BASE) + (off % SPAN));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_mon();
    we_q.delete(); rd_q.delete(); ack_t.delete(); err_q.delete();
    acc_n = 0; ready_bad = 0; stray_err = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  s_ready,  1);
    chk({tag, "_we"},     rf_we,    0);
    chk({tag, "_rvalid"}, s_rvalid, 0);
    chk({tag, "_ack"},    s_ack,    0);
    chk({tag, "_err"},    s_err,    0);
    chk({tag, "_waddr"},  rf_waddr, 0);
    chk({tag, "_wdata"},  rf_wdata, 0);
    chk({tag, "_raddr"},  rf_raddr, 0);
    chk({tag, "_rdata"},  s_rdata,  0);
  endtask

  // One complete bus transaction followed by comparison with the prediction.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input int len,
                         input int mode, input bit hold, input logic [63:0] d0);
    int beats, off0, sent, g, stall_left, n;
    bit stall_done, inwin, v;
    logic [15:0] raddr0, ea;
    logic [63:0] exp_d[$];
    int beat_t[$];

    beats  = len + 1;
    off0   = int'(addr) - int'(BASE);
    inwin  = (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + SPAN);
    raddr0 = rf_raddr;
    clear_mon();

    chk("idle_ready", s_ready, 1);
    s_sel = 1; s_wr = wr; s_addr = addr; s_len = 4'(len);
    @(negedge clk);
    chk("accepted", acc_n, 1);
    if (!hold) s_sel = 0;

    if (inwin && wr) begin
      sent = 0; g = 0; stall_left = 0; stall_done = 0;
      while (sent < beats && g < 300) begin
        if (mode == M_STALL2 && sent == 2 && !stall_done) begin
          stall_left = 2; stall_done = 1;
        end
        if (mode == M_RAND) v = ($urandom_range(0, 2) != 0);
        else v = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        s_valid = v;
        if (v) s_wdata = (sent == 0) ? d0 : rnd64();
        @(negedge clk);
        g++;
        if (v) begin
          beat_t.push_back(edge_n);
          exp_d.push_back(s_wdata);
          sent++;
        end
      end
      s_valid = 0;
    end

    g = 0;
    while (!s_ack && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ack_seen", s_ack, 1);
    s_sel = 0;
    @(negedge clk);
    chk("ready_after", s_ready, 1);
    @(negedge clk);

    chk("accept_once", acc_n, 1);
    chk("ready_low_busy", ready_bad, 0);
    chk("ack_count", ack_t.size(), 1);
    chk("err_alone", stray_err, 0);

    if (!inwin) begin
      chk("oow_no_we", we_q.size(), 0);
      chk("oow_no_rd", rd_q.size(), 0);
      chk("oow_raddr", rf_raddr, raddr0);
      if (ack_t.size() > 0) begin
        chk("oow_ack_t", ack_t[0], acc_edge + 1);
        chk("oow_err", err_q[0], 1);
      end
    end else if (wr) begin
      chk("wr_beats", we_q.size(), beats);
      n = (we_q.size() < beats) ? we_q.size() : beats;
      for (int i = 0; i < beats; i++) begin
        ea = win_addr(off0 + i);
        if (i < n && i < exp_d.size()) begin
          chk("wr_addr", we_q[i].a, ea);
          chk("wr_data", we_q[i].d, exp_d[i]);
          chk("wr_time", we_q[i].t, beat_t[i] + 1);
        end
        if (i < exp_d.size()) ref_mem[ea[7:0]] = exp_d[i];
      end
      chk("wr_no_rd", rd_q.size(), 0);
      if (ack_t.size() > 0 && beat_t.size() > 0) begin
        chk("wr_ack_t", ack_t[0], beat_t[beat_t.size() - 1] + 1);
        chk("wr_err", err_q[0], 0);
      end
    end else begin
      chk("rd_beats", rd_q.size(), beats);
      chk("rd_no_we", we_q.size(), 0);
      n = (rd_q.size() < beats) ? rd_q.size() : beats;
      for (int i = 0; i < n; i++) begin
        ea = win_addr(off0 + i);
        chk("rd_raddr", rd_q[i].a, ea);
        chk("rd_data", rd_q[i].d, ref_mem[ea[7:0]]);
        chk("rd_time", rd_q[i].t, acc_edge + 3 + 2 * i);
      end
      if (ack_t.size() > 0) begin
        chk("rd_ack_t", ack_t[0], acc_edge + 3 + 2 * (beats - 1));
        chk("rd_err", err_q[0], 0);
      end
    end
  endtask

  task automatic reset_mid_write();
    logic [63:0] d [3];
    int g;
    clear_mon();
    s_sel = 1; s_wr = 1; s_addr = 16'h0120; s_len = 4'd7;
    @(negedge clk);
    chk("rst_accepted", acc_n, 1);
    s_sel = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = rnd64();
      s_valid = 1; s_wdata = d[i];
      @(negedge clk);
    end
    chk("rst_pre_we", rf_we, 1);
    #2 reset = 1;
    #1 chk_reset_outputs("rst_mid");
    // Beats 1 and 2 reached the register file; beat 3's strobe was cut short.
    ref_mem[8'h20] = d[0];
    ref_mem[8'h21] = d[1];
    clear_mon();
    busy = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    g = 0;
    repeat (4) begin
      @(negedge clk);
      g++;
    end
    s_valid = 0;
    chk("rst_no_we", we_q.size(), 0);
    chk("rst_no_ack", ack_t.size(), 0);
    chk("rst_ready", s_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1; s_sel = 0; s_wr = 0; s_addr = '0; s_len = '0;
    s_valid = 0; s_wdata = '0; pre_go = 1;
    for (int i = 0; i < 256; i++) begin
      pre_mem[i] = rnd64();
      ref_mem[i] = pre_mem[i];
    end
    #1 chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    pre_go = 0;
    reset  = 0;
    @(negedge clk);

    run_txn(1, 16'h0120, 0, M_NONE,   0, 64'hFFFF_FFFF_FF00_FF00);
    run_txn(1, 16'h0121, 3, M_STALL2, 0, rnd64());
    run_txn(0, 16'h012E, 3, M_NONE,   0, '0);
    run_txn(0, 16'h0130, 0, M_NONE,   0, '0);
    run_txn(1, 16'h011F, 2, M_NONE,   0, rnd64());
    run_txn(0, 16'h0124, 7, M_NONE,   1, '0);
    reset_mid_write();
    run_txn(0, 16'h0122, 0, M_NONE,   0, '0);
    run_txn(0, 16'h0120, 2, M_NONE,   0, '0);
    run_txn(1, 16'h012F, 15, M_RAND,  0, rnd64());
    run_txn(0, 16'h012F, 15, M_NONE,  0, '0);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom_range(0, 1)),
              16'(int'(BASE) - 3 + int'($urandom_range(0, SPAN + 5))),
              int'($urandom_range(0, 15)),
              M_RAND,
              1'($urandom_range(0, 1)),
              rnd64());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "bench time limit");
  end

endmodule
